// File: rtl/qsn_rshift_pipe_pc5.sv
// qsn_rshift_pipe_pc5: two-stage right cyclic shifter (Pc=5) undoing the QSN left rotation.
// Stage 1 applies the 4/2 rotation levels, stage 2 merges the residual 1-lane rotation.
module qsn_rshift_pipe_pc5 #(
    parameter int QUAN_SIZE = 4,
    parameter int PC        = 5,
    parameter int SEL_W     = 3
) (
    input  logic                    sys_clk,
    input  logic                    rstn,
    input  logic [PC*QUAN_SIZE-1:0] msg_in,
    input  logic [SEL_W-1:0]        shift_factor,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [PC*QUAN_SIZE-1:0] msg_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    shift_err
);
    function automatic logic [PC*QUAN_SIZE-1:0] rotr(input logic [PC*QUAN_SIZE-1:0] v, input int amt);
        logic [PC*QUAN_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < PC; i++) r[i*QUAN_SIZE +: QUAN_SIZE] = v[((i + PC - amt) % PC)*QUAN_SIZE +: QUAN_SIZE];
        return r;
    endfunction

    logic                    s1_valid_q, s1_valid_d;
    logic                    out_valid_q, out_valid_d;
    logic                    shift_err_q, shift_err_d;
    logic                    s1_sel0_q, s1_sel0_d;
    logic [PC*QUAN_SIZE-1:0] s1_data_q, s1_data_d;
    logic [PC*QUAN_SIZE-1:0] msg_out_q, msg_out_d;
    logic [PC*QUAN_SIZE-1:0] lvl2, lvl1;
    logic [SEL_W-1:0]        eff_sel;
    logic                    shift_bad, s2_adv, s1_adv, accept;

    always_comb begin
        // Out-of-range factors 5..7 fold to 0..2 with a single subtraction.
        shift_bad   = shift_factor >= SEL_W'(PC);
        eff_sel     = shift_bad ? shift_factor - SEL_W'(PC) : shift_factor;
        lvl2        = eff_sel[2] ? rotr(msg_in, 4) : msg_in;
        lvl1        = eff_sel[1] ? rotr(lvl2, 2) : lvl2;
        s2_adv      = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || s2_adv;
        accept      = in_valid && in_ready;
        s1_adv      = s1_valid_q && s2_adv;
        s1_valid_d  = accept || (s1_valid_q && !s2_adv);
        s1_data_d   = accept ? lvl1 : s1_data_q;
        s1_sel0_d   = accept ? eff_sel[0] : s1_sel0_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        msg_out_d   = s1_adv ? (s1_sel0_q ? rotr(s1_data_q, 1) : s1_data_q) : msg_out_q;
        shift_err_d = shift_err_q || (accept && shift_bad);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            msg_out_q   <= '0;
            shift_err_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            msg_out_q   <= msg_out_d;
            shift_err_q <= shift_err_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        s1_data_q <= s1_data_d;
        s1_sel0_q <= s1_sel0_d;
    end

    assign msg_out   = msg_out_q;
    assign out_valid = out_valid_q;
    assign shift_err = shift_err_q;
endmodule

// File: tb/tb_qsn_rshift_pipe_pc5.sv
// tb_qsn_rshift_pipe_pc5: table vectors plus scoreboarded streaming, stall and reset sequences.
module tb_qsn_rshift_pipe_pc5;
    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic [19:0] msg_in = '0;
    logic [2:0]  shift_factor = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] msg_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        shift_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [19:0] cur_exp = '0;
    logic [19:0] sb[$];

    typedef struct {
        logic [19:0] m;
        logic [2:0]  s;
        logic [19:0] e;
    } vec_t;
    vec_t tbl[7];

    qsn_rshift_pipe_pc5 dut (
        .sys_clk(sys_clk), .rstn(rstn), .msg_in(msg_in), .shift_factor(shift_factor),
        .in_valid(in_valid), .in_ready(in_ready), .msg_out(msg_out), .out_valid(out_valid),
        .out_ready(out_ready), .shift_err(shift_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [19:0] ref_rot(input logic [19:0] m, input int s);
        logic [3:0]  lanes[5];
        logic [19:0] r;
        int e;
        e = s % 5;
        for (int i = 0; i < 5; i++) lanes[i] = m[i*4 +: 4];
        for (int i = 0; i < 5; i++) r[i*4 +: 4] = lanes[(i + 5 - e) % 5];
        return r;
    endfunction

    always @(negedge sys_clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 32'(msg_out), 32'hFFFF_FFFF);
            else chk("msg_out", 32'(msg_out), 32'(sb.pop_front()));
        end
        if (rstn && in_valid && in_ready) sb.push_back(cur_exp);
    end

    // Called at posedge+1; returns with in_valid low at posedge+1 after acceptance.
    task automatic send(input logic [19:0] m, input logic [2:0] s, input logic [19:0] e, output int waits);
        msg_in = m;
        shift_factor = s;
        cur_exp = e;
        in_valid = 1'b1;
        waits = 0;
        do begin
            @(negedge sys_clk);
            waits++;
        end while (!in_ready && waits < 100);
        if (!in_ready) chk("accept_timeout", 32'(waits), 32'd0);
        @(posedge sys_clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic lat_check(input logic [19:0] m, input logic [2:0] s, input logic [19:0] e);
        int w;
        send(m, s, e, w);
        chk("lat_accept_wait", 32'(w), 32'd1);
        @(negedge sys_clk);
        chk("lat_stage1_not_out", 32'(out_valid), 32'd0);
        @(negedge sys_clk);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        drain();
    endtask

    initial begin
        int w, acc, k;
        logic [19:0] hold;
        logic [19:0] bm[6];
        tbl[0] = '{20'h43210, 3'd0, 20'h43210};
        tbl[1] = '{20'h43210, 3'd1, 20'h32104};
        tbl[2] = '{20'h43210, 3'd2, 20'h21043};
        tbl[3] = '{20'h43210, 3'd3, 20'h10432};
        tbl[4] = '{20'h43210, 3'd4, 20'h04321};
        tbl[5] = '{20'hABCDE, 3'd2, 20'hCDEAB};
        tbl[6] = '{20'hABCDE, 3'd0, 20'hABCDE};

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_msg_out", 32'(msg_out), 32'd0);
        chk("rst_shift_err", 32'(shift_err), 32'd0);
        repeat (2) @(negedge sys_clk);
        rstn = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge sys_clk);
        #1;

        lat_check(20'h43210, 3'd0, 20'h43210);
        chk("identity_err", 32'(shift_err), 32'd0);

        foreach (tbl[i]) send(tbl[i].m, tbl[i].s, tbl[i].e, w);
        drain();
        chk("table_err", 32'(shift_err), 32'd0);

        for (int i = 0; i < 10; i++) begin
            logic [19:0] m;
            m = 20'($urandom);
            send(m, 3'(i % 5), ref_rot(m, i % 5), w);
            chk("stream_in_ready", 32'(w), 32'd1);
        end
        drain();

        for (int i = 0; i < 6; i++) bm[i] = 20'($urandom);
        out_ready = 1'b0;
        acc = 0;
        k = 0;
        hold = '0;
        for (int c = 0; c < 5; c++) begin
            msg_in = bm[k];
            shift_factor = 3'(k % 5);
            cur_exp = ref_rot(bm[k], k % 5);
            in_valid = 1'b1;
            @(negedge sys_clk);
            if (c == 2) hold = msg_out;
            if (c == 4) begin
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_msg_out_stable", 32'(msg_out), 32'(hold));
                chk("bp_out_valid", 32'(out_valid), 32'd1);
            end
            if (in_ready) begin
                acc++;
                k++;
            end
            @(posedge sys_clk);
            #1;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        out_ready = 1'b1;
        for (int i = k; i < 6; i++) send(bm[i], 3'(i % 5), ref_rot(bm[i], i % 5), w);
        drain();

        send(20'h43210, 3'd6, 20'h32104, w);
        drain();
        chk("err_set", 32'(shift_err), 32'd1);
        send(20'h43210, 3'd7, 20'h21043, w);
        send(20'hABCDE, 3'd2, 20'hCDEAB, w);
        drain();
        chk("err_sticky", 32'(shift_err), 32'd1);

        out_ready = 1'b0;
        send(20'h43210, 3'd1, 20'h32104, w);
        send(20'h43210, 3'd2, 20'h21043, w);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_msg_out", 32'(msg_out), 32'd0);
        chk("mid_rst_shift_err", 32'(shift_err), 32'd0);
        sb.delete();
        @(negedge sys_clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        lat_check(20'hABCDE, 3'd4, ref_rot(20'hABCDE, 4));
        chk("post_rst_err", 32'(shift_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
